// File: rtl/cjb_clk_pkg.sv
// cjb_clk_pkg: mode encodings and rate arithmetic shared by the step clock generator.
package cjb_clk_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int DB_CYCLES_DEFAULT = 1000000;

    // Half-period in input clock cycles of run rate k; each rate step is 4x faster.
    function automatic int half_period(input int clk_hz, input int k);
        return (clk_hz / 2) >> (2 * k);
    endfunction

endpackage

// File: rtl/cjb_pb_debounce.sv
// cjb_pb_debounce: two-flop synchroniser and level debouncer for an active-low push-button.
module cjb_pb_debounce #(
    parameter int  DB_CYCLES = 1000000,
    localparam int DW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pb_n_i,
    output logic level_o,
    output logic rise_o
);
    logic          s1_q, s2_q, lvl_q, lvl_d, rise_q, rise_d, diff, acc;
    logic [DW-1:0] cnt_q, cnt_d;

    // The counter measures how long the button has disagreed with the accepted level.
    always_comb begin
        diff   = (~s2_q) != lvl_q;
        acc    = diff && (cnt_q == DW'(DB_CYCLES - 1));
        cnt_d  = (!diff || acc) ? '0 : cnt_q + 1'b1;
        lvl_d  = acc ? ~lvl_q : lvl_q;
        rise_d = acc && !lvl_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= pb_n_i;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level_o = lvl_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/cjb_clk_step_gen.sv
// cjb_clk_step_gen: slow processor clock from Clk_50 -- free-run, single-step or halt.
// Defining CJB_TICK_CNT_EN adds a wrapping 32-bit tick counter on output tick_cnt.
module cjb_clk_step_gen
    import cjb_clk_pkg::*;
#(
    parameter int  CLK_FREQ_HZ = 50000000,
    parameter int  NUM_RATES   = 4,
    parameter int  DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int  CNT_W       = $clog2(CLK_FREQ_HZ / 2),
    localparam int RW          = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
    input  logic          Clk_50,
    input  logic          Reset_n,
    input  logic [1:0]    mode_sel,
    input  logic [RW-1:0] rate_sel,
    input  logic          pb_step_n,
    output logic          slow_clk,
    output logic          tick,
    output logic [1:0]    mode,
    output logic          step_db
`ifdef CJB_TICK_CNT_EN
    ,
    output logic [31:0]   tick_cnt
`endif
);
    localparam logic [CNT_W:0] HALF0 = (CNT_W + 1)'(CLK_FREQ_HZ / 2);

    if (half_period(CLK_FREQ_HZ, NUM_RATES - 1) < 2) begin : g_rate_chk
        $error("cjb_clk_step_gen: fastest rate half-period must be at least 2 cycles");
    end

    logic [1:0]       mode_s1_q, mode_s2_q, mode_q, mode_d;
    logic [RW-1:0]    rate_s1_q, rate_s2_q, rate_q, rate_d, rate_c;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W:0]   half;
    logic             slow_q, slow_d, tick_q, tick_d, chg, tc, run, step_lvl, step_rise;

    cjb_pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_pb_debounce (
        .clk_i  (Clk_50),
        .rst_ni (Reset_n),
        .pb_n_i (pb_step_n),
        .level_o(step_lvl),
        .rise_o (step_rise)
    );

    // Rate is resampled only when no half-period is in progress, so periods are never cut short.
    always_comb begin
        mode_d = (mode_s2_q == MODE_RUN || mode_s2_q == MODE_STEP) ? mode_s2_q : MODE_HALT;
        chg    = mode_d != mode_q;
        run    = mode_q == MODE_RUN;
        rate_c = (32'(rate_s2_q) >= NUM_RATES) ? RW'(NUM_RATES - 1) : rate_s2_q;
        half   = HALF0 >> {rate_q, 1'b0};
        tc     = run && ({1'b0, div_q} == half - 1'b1);
        rate_d = (!run || chg || tc) ? rate_c : rate_q;
        div_d  = (!run || chg || tc) ? '0 : div_q + 1'b1;
        slow_d = chg ? 1'b0 :
                 run ? slow_q ^ tc :
                 (mode_q == MODE_STEP) ? (step_rise || (slow_q && step_lvl)) : 1'b0;
        tick_d = !chg && ((tc && !slow_q) || (mode_q == MODE_STEP && step_rise));
    end

    always_ff @(posedge Clk_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_s1_q <= '1;
            mode_s2_q <= '1;
            rate_s1_q <= '1;
            rate_s2_q <= '1;
            mode_q    <= MODE_HALT;
            rate_q    <= '0;
            div_q     <= '0;
            slow_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            mode_s1_q <= mode_sel;
            mode_s2_q <= mode_s1_q;
            rate_s1_q <= rate_sel;
            rate_s2_q <= rate_s1_q;
            mode_q    <= mode_d;
            rate_q    <= rate_d;
            div_q     <= div_d;
            slow_q    <= slow_d;
            tick_q    <= tick_d;
        end
    end

`ifdef CJB_TICK_CNT_EN
    logic [31:0] tick_cnt_q;

    always_ff @(posedge Clk_50 or negedge Reset_n) begin
        if (!Reset_n) tick_cnt_q <= '0;
        else if (tick_d) tick_cnt_q <= tick_cnt_q + 32'd1;
    end

    assign tick_cnt = tick_cnt_q;
`endif

    assign slow_clk = slow_q;
    assign tick     = tick_q;
    assign mode     = mode_q;
    assign step_db  = step_lvl;

endmodule

// File: tb/tb_cjb_clk_step_gen.sv
// tb_cjb_clk_step_gen: randomized scenario bench for the step clock generator.
// Expectations are derived from edge counts since each stimulus change.
module tb_cjb_clk_step_gen;
    import cjb_clk_pkg::*;

    localparam int CLK_HZ = 2048;
    localparam int NR     = 4;
    localparam int DB     = 8;

    logic       Clk_50    = 1'b0;
    logic       Reset_n   = 1'b1;
    logic [1:0] mode_sel  = 2'b00;
    logic [1:0] rate_sel  = 2'b11;
    logic       pb_step_n = 1'b1;
    logic       slow_clk, tick, step_db;
    logic [1:0] mode;
`ifdef CJB_TICK_CNT_EN
    logic [31:0] tick_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 Clk_50 = ~Clk_50;

    cjb_clk_step_gen #(.CLK_FREQ_HZ(CLK_HZ), .NUM_RATES(NR), .DB_CYCLES(DB)) dut (
        .Clk_50   (Clk_50),
        .Reset_n  (Reset_n),
        .mode_sel (mode_sel),
        .rate_sel (rate_sel),
        .pb_step_n(pb_step_n),
        .slow_clk (slow_clk),
        .tick     (tick),
        .mode     (mode),
        .step_db  (step_db)
`ifdef CJB_TICK_CNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    function automatic int ref_half(input int r);
        return (CLK_HZ / 2) / (4 ** ((r >= NR) ? NR - 1 : r));
    endfunction

    task automatic cyc();
        @(posedge Clk_50);
        #1;
    endtask

    task automatic go_halt();
        mode_sel = ($urandom_range(0, 1) != 0) ? 2'b11 : MODE_HALT;
        repeat (3) cyc();
        nvec++;
        if (mode !== MODE_HALT || slow_clk !== 1'b0) begin
            nerr++;
            $display("FAIL halt_entry: mode=%b slow=%b, want mode=00 slow=0", mode, slow_clk);
        end
    endtask

    task automatic start_run(input int r);
        go_halt();
        rate_sel = 2'(r);
        mode_sel = MODE_RUN;
        repeat (2) cyc();
        nvec++;
        if (mode !== MODE_HALT) begin
            nerr++;
            $display("FAIL run_sync_delay: mode=%b, want 00", mode);
        end
        cyc();
        nvec++;
        if (mode !== MODE_RUN || slow_clk !== 1'b0 || tick !== 1'b0) begin
            nerr++;
            $display("FAIL run_entry: mode=%b slow=%b tick=%b, want 01 0 0", mode, slow_clk, tick);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) cyc();
        nvec++;
        if (slow_clk !== 1'b0 || tick !== 1'b0 || mode !== MODE_HALT || step_db !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: slow=%b tick=%b mode=%b db=%b, want 0 0 00 0", slow_clk, tick, mode, step_db);
        end
`ifdef CJB_TICK_CNT_EN
        nvec++;
        if (tick_cnt !== 32'd0) begin
            nerr++;
            $display("FAIL reset_tick_cnt: got %h want 0", tick_cnt);
        end
`endif
        Reset_n = 1'b1;
        repeat (4) cyc();
        nvec++;
        if (mode !== MODE_HALT || slow_clk !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: mode=%b slow=%b, want 00 0", mode, slow_clk);
        end
    endtask

    task automatic test_run(input int r);
        int   h, n;
        logic es, et;
        h = ref_half(r);
        n = 0;
        start_run(r);
        for (int p = 0; p < 8 * h; p++) begin
            if (p > 0) cyc();
            es = ((p / h) % 2) == 1;
            et = (p % (2 * h)) == h;
            if (tick) n++;
            nvec++;
            if (slow_clk !== es || tick !== et) begin
                nerr++;
                $display("FAIL run r=%0d p=%0d: slow=%b tick=%b, want %b %b", r, p, slow_clk, tick, es, et);
            end
        end
        nvec++;
        if (n != 4) begin
            nerr++;
            $display("FAIL run_tick_count r=%0d: got %0d want 4", r, n);
        end
    endtask

    task automatic test_rate_change();
        int   s, q;
        logic es, et;
        s = $urandom_range(17, 29);
        start_run(3);
        for (int p = 0; p < 224; p++) begin
            if (p > 0) cyc();
            if (p < 32) begin
                es = p >= 16;
                et = p == 16;
            end else begin
                q  = p - 32;
                es = ((q / 64) % 2) == 1;
                et = (q % 128) == 64;
            end
            nvec++;
            if (slow_clk !== es || tick !== et) begin
                nerr++;
                $display("FAIL rate_change s=%0d p=%0d: slow=%b tick=%b, want %b %b", s, p, slow_clk, tick, es, et);
            end
            if (p == s) rate_sel = 2'd2;
        end
    endtask

    task automatic test_halt();
        int s;
        s = $urandom_range(17, 28);
        start_run(3);
        repeat (s) cyc();
        mode_sel = ($urandom_range(0, 1) != 0) ? 2'b11 : MODE_HALT;
        repeat (2) begin
            cyc();
            nvec++;
            if (mode !== MODE_RUN || slow_clk !== 1'b1 || tick !== 1'b0) begin
                nerr++;
                $display("FAIL halt_pending: mode=%b slow=%b tick=%b, want 01 1 0", mode, slow_clk, tick);
            end
        end
        cyc();
        nvec++;
        if (mode !== MODE_HALT || slow_clk !== 1'b0 || tick !== 1'b0) begin
            nerr++;
            $display("FAIL halt_switch: mode=%b slow=%b tick=%b, want 00 0 0", mode, slow_clk, tick);
        end
        for (int i = 0; i < 500; i++) begin
            cyc();
            nvec++;
            if (slow_clk !== 1'b0 || tick !== 1'b0) begin
                nerr++;
                $display("FAIL halt_hold i=%0d: slow=%b tick=%b, want 0 0", i, slow_clk, tick);
            end
        end
    endtask

    task automatic test_step();
        int   g, l, n;
        logic ed, es, et;
        go_halt();
        mode_sel = MODE_STEP;
        repeat (3) cyc();
        nvec++;
        if (mode !== MODE_STEP || slow_clk !== 1'b0) begin
            nerr++;
            $display("FAIL step_entry: mode=%b slow=%b, want 10 0", mode, slow_clk);
        end
        g = $urandom_range(1, DB - 1);
        pb_step_n = 1'b0;
        repeat (g) cyc();
        pb_step_n = 1'b1;
        for (int i = 0; i < DB + 6; i++) begin
            cyc();
            nvec++;
            if (step_db !== 1'b0 || tick !== 1'b0 || slow_clk !== 1'b0) begin
                nerr++;
                $display("FAIL step_glitch g=%0d: db=%b tick=%b slow=%b, want 0 0 0", g, step_db, tick, slow_clk);
            end
        end
        l = $urandom_range(DB + 4, 30);
        n = 0;
        pb_step_n = 1'b0;
        for (int i = 1; i <= l + DB + 6; i++) begin
            cyc();
            if (i == l) pb_step_n = 1'b1;
            ed = (i >= 2 + DB) && (i < l + 2 + DB);
            es = (i >= 3 + DB) && (i < l + 3 + DB);
            et = i == 3 + DB;
            if (tick) n++;
            nvec++;
            if (step_db !== ed || slow_clk !== es || tick !== et) begin
                nerr++;
                $display("FAIL step_press l=%0d i=%0d: db=%b slow=%b tick=%b, want %b %b %b", l, i, step_db, slow_clk, tick, ed, es, et);
            end
        end
        nvec++;
        if (n != 1) begin
            nerr++;
            $display("FAIL step_tick_count: got %0d want 1", n);
        end
    endtask

    task automatic test_held_entry();
        logic ed;
        go_halt();
        pb_step_n = 1'b0;
        for (int i = 1; i <= DB + 4; i++) begin
            cyc();
            ed = i >= 2 + DB;
            nvec++;
            if (step_db !== ed || slow_clk !== 1'b0 || tick !== 1'b0) begin
                nerr++;
                $display("FAIL held_in_halt i=%0d: db=%b slow=%b tick=%b, want %b 0 0", i, step_db, slow_clk, tick, ed);
            end
        end
        mode_sel = MODE_STEP;
        repeat (3) cyc();
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (mode !== MODE_STEP || step_db !== 1'b1 || slow_clk !== 1'b0 || tick !== 1'b0) begin
                nerr++;
                $display("FAIL held_entry i=%0d: mode=%b db=%b slow=%b tick=%b, want 10 1 0 0", i, mode, step_db, slow_clk, tick);
            end
            cyc();
        end
        pb_step_n = 1'b1;
        for (int i = 1; i <= DB + 4; i++) begin
            cyc();
            ed = i < 2 + DB;
            nvec++;
            if (step_db !== ed || slow_clk !== 1'b0 || tick !== 1'b0) begin
                nerr++;
                $display("FAIL held_release i=%0d: db=%b slow=%b tick=%b, want %b 0 0", i, step_db, slow_clk, tick, ed);
            end
        end
        pb_step_n = 1'b0;
        for (int i = 1; i <= DB + 6; i++) begin
            cyc();
            nvec++;
            if (tick !== (i == 3 + DB) || slow_clk !== (i >= 3 + DB)) begin
                nerr++;
                $display("FAIL held_repress i=%0d: tick=%b slow=%b, want %b %b", i, tick, slow_clk, i == 3 + DB, i >= 3 + DB);
            end
        end
        pb_step_n = 1'b1;
        repeat (DB + 4) cyc();
    endtask

    task automatic test_reset_mid();
        int   s;
        logic es, et;
        s = $urandom_range(1, 30);
        start_run(3);
        repeat (s) cyc();
        Reset_n = 1'b0;
        #1;
        nvec++;
        if (slow_clk !== 1'b0 || tick !== 1'b0 || mode !== MODE_HALT || step_db !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid s=%0d: slow=%b tick=%b mode=%b db=%b, want 0 0 00 0", s, slow_clk, tick, mode, step_db);
        end
        cyc();
        Reset_n = 1'b1;
        repeat (2) cyc();
        nvec++;
        if (mode !== MODE_HALT || slow_clk !== 1'b0) begin
            nerr++;
            $display("FAIL reset_resync: mode=%b slow=%b, want 00 0", mode, slow_clk);
        end
        cyc();
        for (int p = 0; p < 64; p++) begin
            if (p > 0) cyc();
            es = ((p / 16) % 2) == 1;
            et = (p % 32) == 16;
            nvec++;
            if (mode !== MODE_RUN || slow_clk !== es || tick !== et) begin
                nerr++;
                $display("FAIL reset_rerun p=%0d: mode=%b slow=%b tick=%b, want 01 %b %b", p, mode, slow_clk, tick, es, et);
            end
        end
    endtask

`ifdef CJB_TICK_CNT_EN
    task automatic test_tick_cnt();
        logic [31:0] ec;
        ec = 32'hFFFF_FFFE;
        start_run(3);
        force dut.tick_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.tick_cnt_q;
        for (int p = 1; p < 60; p++) begin
            cyc();
            if (p % 32 == 16) ec = ec + 32'd1;
            nvec++;
            if (tick_cnt !== ec) begin
                nerr++;
                $display("FAIL tick_cnt p=%0d: got %h want %h", p, tick_cnt, ec);
            end
        end
        nvec++;
        if (tick_cnt !== 32'd0) begin
            nerr++;
            $display("FAIL tick_cnt_wrap: got %h want 00000000", tick_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run(3);
        test_run($urandom_range(1, 3));
        test_rate_change();
        test_halt();
        test_step();
        test_held_entry();
        test_reset_mid();
`ifdef CJB_TICK_CNT_EN
        test_tick_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
